// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - two-street traffic-light lamp bus
interface traffic_light_monitor_if;
  logic [2:0] street_a;
  logic [2:0] street_b;

  modport master (output street_a, output street_b);
  modport slave  (input  street_a, input  street_b);
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker for the traffic-light lamp bus
// Optional duration checking is compiled in with MON_TIMING_CHECK_EN.
module traffic_light_monitor #(
  parameter int G_CYC = 10,
  parameter int Y_CYC = 3,
  parameter int R_CYC = 13,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_err,
  traffic_light_monitor_if.slave lights,
  output logic                   err_enc,
  output logic                   err_conflict,
  output logic                   err_seq,
  output logic                   err_timing,
  output logic                   err_any,
  output logic                   phase_done_a,
  output logic                   phase_done_b,
  output logic [CNT_W-1:0]       last_len_a,
  output logic [CNT_W-1:0]       last_len_b,
  output logic [15:0]            cycle_cnt
);

  typedef enum logic [2:0] {PH_NONE, PH_G, PH_Y, PH_R, PH_BAD} phase_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  phase_t           cur      [2];
  phase_t           prev_q   [2];
  phase_t           prev_d   [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];
  logic [CNT_W-1:0] len_q    [2];
  logic [CNT_W-1:0] len_d    [2];
  logic [1:0]       first_q, first_d;
  logic [1:0]       done_q, done_d;
  logic [15:0]      cyc_q, cyc_d;
  logic             enc_q, enc_d, conf_q, conf_d, seq_q, seq_d, any_q, any_d;
  logic             seq_hit, tim_d;

  function automatic phase_t decode(input logic [2:0] s);
    case (s)
      3'b001:  return PH_G;
      3'b010:  return PH_Y;
      3'b100:  return PH_R;
      default: return PH_BAD;
    endcase
  endfunction

  function automatic logic legal(input phase_t p, input phase_t c);
    return (p == PH_G && c == PH_Y) || (p == PH_Y && c == PH_R) || (p == PH_R && c == PH_G);
  endfunction

`ifdef MON_TIMING_CHECK_EN
  logic tim_q, tim_hit;

  function automatic logic [CNT_W-1:0] expected(input phase_t p);
    case (p)
      PH_G:    return CNT_W'(G_CYC);
      PH_Y:    return CNT_W'(Y_CYC);
      PH_R:    return CNT_W'(R_CYC);
      default: return '0;
    endcase
  endfunction
`endif

  always_comb begin
    cur[0]  = decode(lights.street_a);
    cur[1]  = decode(lights.street_b);
    seq_hit = 1'b0;
    cyc_d   = cyc_q;
`ifdef MON_TIMING_CHECK_EN
    tim_hit = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      prev_d[i]  = cur[i];
      cnt_d[i]   = cnt_q[i];
      len_d[i]   = len_q[i];
      first_d[i] = first_q[i];
      done_d[i]  = 1'b0;
      if (prev_q[i] == PH_NONE) begin
        cnt_d[i] = CNT_ONE;
      end else if (cur[i] == prev_q[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        done_d[i]  = 1'b1;
        len_d[i]   = cnt_q[i];
        cnt_d[i]   = CNT_ONE;
        first_d[i] = 1'b0;
        // BAD transitions are reported through err_enc only
        if (prev_q[i] != PH_BAD && cur[i] != PH_BAD && !legal(prev_q[i], cur[i]))
          seq_hit = 1'b1;
`ifdef MON_TIMING_CHECK_EN
        if (!first_q[i] && prev_q[i] != PH_BAD && cnt_q[i] != expected(prev_q[i]))
          tim_hit = 1'b1;
`endif
        if (i == 0 && prev_q[i] == PH_R && cur[i] == PH_G) cyc_d = cyc_q + 16'd1;
      end
    end
    enc_d  = (enc_q & ~clr_err) | (cur[0] == PH_BAD) | (cur[1] == PH_BAD);
    conf_d = (conf_q & ~clr_err) |
             ((cur[0] == PH_G || cur[0] == PH_Y) && (cur[1] == PH_G || cur[1] == PH_Y));
    seq_d  = (seq_q & ~clr_err) | seq_hit;
`ifdef MON_TIMING_CHECK_EN
    tim_d  = (tim_q & ~clr_err) | tim_hit;
`else
    tim_d  = 1'b0;
`endif
    any_d  = enc_d | conf_d | seq_d | tim_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_q[i] <= PH_NONE;
        cnt_q[i]  <= '0;
        len_q[i]  <= '0;
      end
      first_q <= 2'b11;
      done_q  <= 2'b00;
      cyc_q   <= '0;
      enc_q   <= 1'b0;
      conf_q  <= 1'b0;
      seq_q   <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        prev_q[i] <= prev_d[i];
        cnt_q[i]  <= cnt_d[i];
        len_q[i]  <= len_d[i];
      end
      first_q <= first_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      enc_q   <= enc_d;
      conf_q  <= conf_d;
      seq_q   <= seq_d;
      any_q   <= any_d;
    end
  end

`ifdef MON_TIMING_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) tim_q <= 1'b0;
    else        tim_q <= tim_d;
  end
  assign err_timing = tim_q;
`else
  assign err_timing = 1'b0;
`endif

  assign err_enc      = enc_q;
  assign err_conflict = conf_q;
  assign err_seq      = seq_q;
  assign err_any      = any_q;
  assign phase_done_a = done_q[0];
  assign phase_done_b = done_q[1];
  assign last_len_a   = len_q[0];
  assign last_len_b   = len_q[1];
  assign cycle_cnt    = cyc_q;

endmodule
